// File: rtl/pipe_controller_if.sv
// ID-stage inputs and registered ID/EX control outputs of the pipeline controller.
// The core drives through the master modport; the controller implements the slave modport.
interface pipe_controller_if #(
   parameter int REG_AW = 4
) ();
   logic              id_valid;
   logic [3:0]        id_opcode;
   logic [REG_AW-1:0] id_rd;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              flush;
   logic              stall;
   logic              ex_valid;
   logic              ex_reg_dst;
   logic              ex_branch;
   logic              ex_mem_read;
   logic              ex_mem_to_reg;
   logic              ex_mem_write;
   logic              ex_alu_src;
   logic              ex_reg_write;
   logic              ex_jal;
   logic              ex_jr;
   logic [3:0]        ex_opcode;
   logic [REG_AW-1:0] ex_rd;
   logic              halted;

   modport master (
      output id_valid, id_opcode, id_rd, id_rs, id_rt, flush,
      input  stall, ex_valid, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg,
             ex_mem_write, ex_alu_src, ex_reg_write, ex_jal, ex_jr, ex_opcode, ex_rd, halted
   );

   modport slave (
      input  id_valid, id_opcode, id_rd, id_rs, id_rt, flush,
      output stall, ex_valid, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg,
             ex_mem_write, ex_alu_src, ex_reg_write, ex_jal, ex_jr, ex_opcode, ex_rd, halted
   );
endinterface

// File: rtl/pipe_controller.sv
// ID-stage decode into ID/EX control, RAW hazard stall/bubble, flush squash, HLT drain-then-halt.
// Define PIPE_CONTROLLER_FWD_EN when EX/MEM forwarding exists (stall only on load-use).
module pipe_controller #(
   parameter int REG_AW       = 4,
   parameter int DRAIN_CYCLES = 3
) (
   input logic             clk,
   input logic             rst_n,
   pipe_controller_if.slave pc
);
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   typedef struct packed {
      logic reg_dst;
      logic branch;
      logic mem_read;
      logic mem_to_reg;
      logic mem_write;
      logic alu_src;
      logic reg_write;
      logic jal;
      logic jr;
   } ctrl_t;

   localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              ex_valid_q, ex_valid_d;
   ctrl_t             ctrl_q, ctrl_d;
   logic [3:0]        ex_opcode_q, ex_opcode_d;
   logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
   logic              halted_q, halted_d;
   logic              hz, qual, run;

   function automatic ctrl_t decode(input logic [3:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         4'h8: begin c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1; end
         4'h9: begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
         4'hA: begin c.reg_dst = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1; end
         4'hB: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
         4'hC: c.branch = 1'b1;
         4'hD: begin c.jal = 1'b1; c.reg_write = 1'b1; end
         4'hE: c.jr = 1'b1;
         4'hF: c = '0;
         default: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      endcase
      return c;
   endfunction

`ifdef PIPE_CONTROLLER_FWD_EN
   assign qual = ctrl_q.mem_read;
`else
   assign qual = ctrl_q.reg_write;
`endif

   // Both source fields are compared for every opcode; r0 never carries a dependency.
   assign hz  = pc.id_valid & ex_valid_q & (ex_rd_q != '0) &
                ((ex_rd_q == pc.id_rs) | (ex_rd_q == pc.id_rt)) & qual;
   assign run = (state_q == RUN);
   assign pc.stall = ~run | (hz & ~pc.flush);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      halted_d    = halted_q | (state_q == HALTED);
      ex_valid_d  = 1'b0;
      ctrl_d      = '0;
      ex_opcode_d = '0;
      ex_rd_d     = '0;
      case (state_q)
         RUN: begin
            if (pc.id_valid && pc.id_opcode == 4'hF && !pc.flush && !hz) begin
               state_d = DRAIN;
               cnt_d   = DRAIN_LOAD;
            end
         end
         DRAIN: begin
            if (cnt_q == 8'd0) state_d = HALTED;
            else               cnt_d   = cnt_q - 8'd1;
         end
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
      // HLT takes this path too: it decodes to all-zero controls with ex_valid set.
      if (!pc.flush && run && !hz && pc.id_valid) begin
         ex_valid_d  = 1'b1;
         ctrl_d      = decode(pc.id_opcode);
         ex_opcode_d = pc.id_opcode;
         ex_rd_d     = pc.id_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RUN;
         cnt_q       <= 8'd0;
         ex_valid_q  <= 1'b0;
         ctrl_q      <= '0;
         ex_opcode_q <= '0;
         ex_rd_q     <= '0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ex_valid_q  <= ex_valid_d;
         ctrl_q      <= ctrl_d;
         ex_opcode_q <= ex_opcode_d;
         ex_rd_q     <= ex_rd_d;
         halted_q    <= halted_d;
      end
   end

   assign pc.ex_valid      = ex_valid_q;
   assign pc.ex_reg_dst    = ctrl_q.reg_dst;
   assign pc.ex_branch     = ctrl_q.branch;
   assign pc.ex_mem_read   = ctrl_q.mem_read;
   assign pc.ex_mem_to_reg = ctrl_q.mem_to_reg;
   assign pc.ex_mem_write  = ctrl_q.mem_write;
   assign pc.ex_alu_src    = ctrl_q.alu_src;
   assign pc.ex_reg_write  = ctrl_q.reg_write;
   assign pc.ex_jal        = ctrl_q.jal;
   assign pc.ex_jr         = ctrl_q.jr;
   assign pc.ex_opcode     = ex_opcode_q;
   assign pc.ex_rd         = ex_rd_q;
   assign pc.halted        = halted_q;
endmodule

// File: tb/tb_pipe_controller.sv
// Bench for pipe_controller: directed scenarios plus random traffic against a cycle-level reference model.
module tb_pipe_controller;
   localparam int AW = 4;
   localparam int DC = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipe_controller_if #(.REG_AW(AW)) pc_if ();

   pipe_controller #(.REG_AW(AW), .DRAIN_CYCLES(DC)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .pc   (pc_if)
   );

   int n_total = 0;
   int n_pass  = 0;

   // Reference state: contents of ID/EX plus a countdown of edges until halted rises.
   logic          m_init = 1'b0;
   logic          m_valid;
   logic [8:0]    m_ctrl;    // {reg_dst,branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write,jal,jr}
   logic [3:0]    m_op;
   logic [AW-1:0] m_rd;
   logic          m_drain, m_halt;
   int            m_rem;
   logic          last_stall;

   function automatic logic [8:0] ref_ctrl(input logic [3:0] op);
      logic [8:0] tab [16];
      for (int i = 0; i < 8; i++) tab[i] = 9'h104;
      tab[8]  = 9'h06C;  tab[9]  = 9'h018;  tab[10] = 9'h10C;  tab[11] = 9'h104;
      tab[12] = 9'h080;  tab[13] = 9'h006;  tab[14] = 9'h001;  tab[15] = 9'h000;
      return tab[op];
   endfunction

   function automatic logic [8:0] dut_ctrl();
      return {pc_if.ex_reg_dst, pc_if.ex_branch, pc_if.ex_mem_read, pc_if.ex_mem_to_reg,
              pc_if.ex_mem_write, pc_if.ex_alu_src, pc_if.ex_reg_write, pc_if.ex_jal, pc_if.ex_jr};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total = n_total + 1;
      assert (obs === expv) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // One cycle: drive ID inputs, check stall, model the edge, check registered outputs.
   task automatic step(input logic r, input logic v, input logic [3:0] op,
                       input logic [AW-1:0] rd, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic fl);
      logic qual, hz, run, n_valid;
      logic [8:0] n_ctrl;
      rst_n = r;
      pc_if.id_valid = v; pc_if.id_opcode = op;
      pc_if.id_rd = rd; pc_if.id_rs = rs; pc_if.id_rt = rt; pc_if.flush = fl;
      #1;
`ifdef PIPE_CONTROLLER_FWD_EN
      qual = m_ctrl[6];
`else
      qual = m_ctrl[2];
`endif
      hz  = m_init && v && m_valid && (m_rd != 0) && ((m_rd == rs) || (m_rd == rt)) && qual;
      run = !m_drain && !m_halt;
      last_stall = pc_if.stall;
      if (m_init) chk("stall", 32'(pc_if.stall), 32'(!run || (hz && !fl)));
      if (!r) begin
         m_valid = 1'b0; m_ctrl = '0; m_op = '0; m_rd = '0;
         m_drain = 1'b0; m_halt = 1'b0; m_rem = 0; m_init = 1'b1;
      end else begin
         n_valid = 1'b0; n_ctrl = '0;
         if (!fl && run && !hz && v) begin
            n_valid = 1'b1; n_ctrl = ref_ctrl(op); m_op = op; m_rd = rd;
         end
         if (m_drain) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin m_drain = 1'b0; m_halt = 1'b1; end
         end else if (run && v && op == 4'hF && !fl && !hz) begin
            m_drain = 1'b1; m_rem = DC + 1;
         end
         m_valid = n_valid; m_ctrl = n_ctrl;
      end
      @(posedge clk);
      @(negedge clk);
      chk("ex_valid", 32'(pc_if.ex_valid), 32'(m_valid));
      chk("ex_ctrl", 32'(dut_ctrl()), 32'(m_ctrl));
      chk("halted", 32'(pc_if.halted), 32'(m_halt));
      if (m_valid) begin
         chk("ex_opcode", 32'(pc_if.ex_opcode), 32'(m_op));
         chk("ex_rd", 32'(pc_if.ex_rd), 32'(m_rd));
      end
   endtask

   initial begin
      logic [3:0]    op;
      logic [AW-1:0] rd, rs, rt;
      logic          v, fl, r;
      m_valid = 0; m_ctrl = 0; m_op = 0; m_rd = 0; m_drain = 0; m_halt = 0; m_rem = 0;
      last_stall = 0;
      pc_if.id_valid = 0; pc_if.id_opcode = 0; pc_if.id_rd = 0; pc_if.id_rs = 0;
      pc_if.id_rt = 0; pc_if.flush = 0;
      @(negedge clk);

      // Reset held two cycles with a valid ALU op in ID.
      step(0, 1, 4'h0, 1, 0, 0, 0);
      step(0, 1, 4'h0, 1, 0, 0, 0);
      chk("rst_ex_valid", 32'(pc_if.ex_valid), 0);
      chk("rst_ctrl", 32'(dut_ctrl()), 0);
      step(1, 1, 4'h0, 1, 2, 2, 0);
      chk("rel_reg_dst", 32'(pc_if.ex_reg_dst), 1);
      chk("rel_reg_write", 32'(pc_if.ex_reg_write), 1);

      // Load-use: LW r3 then ADD using r3, then with r0 on both sides.
      step(1, 1, 4'h8, 3, 0, 0, 0);
      step(1, 1, 4'h0, 4, 3, 0, 0);
      chk("lu_stall", 32'(last_stall), 1);
      chk("lu_bubble", 32'(pc_if.ex_valid), 0);
      step(1, 1, 4'h0, 4, 3, 0, 0);
      chk("lu_issue_stall", 32'(last_stall), 0);
      chk("lu_issue_op", 32'(pc_if.ex_opcode), 0);
      step(1, 1, 4'h8, 0, 1, 1, 0);
      step(1, 1, 4'h0, 6, 0, 0, 0);
      chk("r0_no_stall", 32'(last_stall), 0);

      // ALU RAW: stalls only without forwarding.
      step(1, 1, 4'h0, 5, 1, 1, 0);
      step(1, 1, 4'h1, 7, 2, 5, 0);
`ifdef PIPE_CONTROLLER_FWD_EN
      chk("raw_stall", 32'(last_stall), 0);
`else
      chk("raw_stall", 32'(last_stall), 1);
      step(1, 1, 4'h1, 7, 2, 5, 0);
`endif

      // Flush beats a load-use hazard; flushed HLT stays in RUN.
      step(1, 1, 4'h8, 3, 1, 1, 0);
      step(1, 1, 4'h0, 4, 3, 3, 1);
      chk("fl_stall", 32'(last_stall), 0);
      chk("fl_bubble", 32'(pc_if.ex_valid), 0);
      step(1, 1, 4'hF, 0, 0, 0, 1);
      step(1, 1, 4'h0, 2, 1, 1, 0);
      chk("fl_hlt_run", 32'(last_stall), 0);
      chk("fl_hlt_halted", 32'(pc_if.halted), 0);

      // Halt: HLT at edge N, halted after edge N+4, flushes in DRAIN ignored.
      step(1, 1, 4'hF, 0, 0, 0, 0);
      for (int k = 1; k <= 6; k++) begin
         step(1, 1, 4'h0, 1, 0, 0, logic'(k % 2));
         chk("hlt_stall", 32'(last_stall), 1);
         chk("hlt_timing", 32'(pc_if.halted), 32'(k >= DC + 1));
      end
      step(0, 0, 4'h0, 0, 0, 0, 0);
      chk("hlt_rst", 32'(pc_if.halted), 0);

      // Decode sweep with rs=rt=0 so no hazards arise.
      for (int o = 0; o < 16; o++) step(1, 1, 4'(o), 4'(o), 0, 0, 0);
      step(0, 0, 4'h0, 0, 0, 0, 0);
      step(1, 0, 4'h3, 2, 0, 0, 0);
      chk("idle_bubble", 32'(pc_if.ex_valid), 0);

      // Random traffic: stalled instructions are held in ID unless flushed.
      op = 0; rd = 0; rs = 0; rt = 0; v = 0;
      for (int c = 0; c < 600; c++) begin
         fl = ($urandom_range(0, 7) == 0);
         r  = !((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0);
         if (!last_stall || fl || c == 0) begin
            v  = ($urandom_range(0, 7) != 0);
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 5) != 0) op = 4'($urandom_range(0, 14));
            rd = AW'($urandom_range(0, 3));
            rs = AW'($urandom_range(0, 3));
            rt = AW'($urandom_range(0, 3));
         end
         step(r, v, op, rd, rs, rt, fl);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/pipe_controller.md
# pipe_controller

Pipelined successor to the single-cycle opcode decoder. It sits between the IF/ID and ID/EX registers of the 5-stage core. It decodes the 4-bit opcode into registered ID/EX control bits and detects RAW hazards against the instruction in EX, inserting bubbles and stalling fetch when one is found. It also flushes on taken branches and sequences HLT through a drain-then-halt state machine.

## Interface
Parameters:
- REG_AW, 4, register-address width
- DRAIN_CYCLES, 3, cycles spent in DRAIN before halting (1..2^8-1)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk edge
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  4  opcode in ID
- id_rd, id_rs, id_rt  in  REG_AW each  register fields in ID
- flush  in  1  taken branch/jump resolved in EX; squash ID
- stall  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid  out  1  ID/EX holds a real instruction
- ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_jal, ex_jr  out  1 each  registered control bits
- ex_opcode  out  4  registered opcode
- ex_rd  out  REG_AW  registered destination
- halted  out  1  core halted; sticky until reset

## Operation
- Decode (all unlisted bits 0):
  - 0x0–0x7 (ALU): reg_dst, reg_write
  - 0x8 LW: mem_read, mem_to_reg, alu_src, reg_write
  - 0x9 SW: mem_write, alu_src
  - 0xA LLB: reg_dst, alu_src, reg_write
  - 0xB LHB: reg_dst, reg_write
  - 0xC B: branch
  - 0xD JAL: jal, reg_write
  - 0xE JR: jr
  - 0xF HLT: none
- Hazard (hz): id_valid & ex_valid & ex_rd≠0 & (ex_rd==id_rs | ex_rd==id_rt) & qualifier.
  - Qualifier is ex_mem_read, or ex_reg_write (see Configuration).
  - Both rs and rt are compared for every opcode, conservatively.
- Bubble: ex_valid and all ex_* control bits 0. ex_opcode and ex_rd are don't-care.
- Per-cycle ID/EX update, in priority order:
  1. reset
  2. flush → bubble
  3. state≠RUN → bubble
  4. hz → bubble
  5. id_valid → decode
  6. otherwise → bubble
- stall = hz & ~flush & state==RUN, or state≠RUN.
- FSM states: RUN, DRAIN, HALTED.
  - RUN→DRAIN when id_valid & id_opcode==0xF & ~flush & ~hz. HLT itself enters ID/EX as a bubble-equivalent (ex_valid=1, all controls 0). Counter loads DRAIN_CYCLES-1.
  - DRAIN: counter decrements each cycle; at 0 → HALTED. flush is ignored.
  - HALTED: absorbing; halted=1; only rst_n exits.
- HLT squashed by flush does not leave RUN.
- Register address 0 never creates a hazard.

## Timing
- Reset (rst_n low at edge): all ex_* = 0, ex_valid=0, halted=0, state=RUN, counter=0. stall=0 in the cycle after reset, provided inputs create no hazard.
- Decode latency: 1 cycle, ID inputs to ex_* outputs.
- stall is combinational, valid in the same cycle as the ID inputs.
- Load-use with forwarding: exactly 1 stall cycle, then the dependent instruction issues.
- halted rises DRAIN_CYCLES+1 edges after the edge at which HLT was in ID.
- Reset mid-DRAIN or in HALTED returns to RUN on that edge.

## Configuration
- PIPE_CONTROLLER_FWD_EN
  - Defined: EX/MEM forwarding exists; qualifier = ex_mem_read (load-use only).
  - Undefined: no forwarding; qualifier = ex_reg_write (stall on any RAW against EX).

## Test plan
- Reset: hold rst_n=0 for 2 cycles with id_opcode=0x0, id_valid=1 → every output 0 after each edge. Release → ex_reg_dst=1, ex_reg_write=1 one edge later.
- Load-use (FWD_EN defined): LW rd=3 then ADD rs=3 → stall=1 for exactly 1 cycle, one bubble, ADD issues next. Repeat with ADD rs=0 and LW rd=0 → no stall.
- RAW without FWD_EN: ADD rd=5 then SUB rt=5 → stall=1 for 1 cycle. With FWD_EN defined → no stall.
- Flush priority: flush=1 in the same cycle as a load-use hazard → stall=0, ID/EX bubble. Flush on HLT in ID → state stays RUN, halted stays 0.
- Halt (DRAIN_CYCLES=3): HLT in ID at edge N → stall=1 from edge N. halted=1 after edge N+4. flush pulses during DRAIN have no effect. rst_n=0 then clears halted.
- Full decode sweep: opcodes 0x0–0xF with id_valid=1 and no hazards → ex_* match the decode list one cycle later. id_valid=0 → bubble.
